// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer, one bit per cycle.
// Multiply: shift-and-add on operand magnitudes. Divide: restoring shift-and-subtract.
// Optional macro MULDIV_EARLY_OUT_EN: divide-by-zero and signed overflow finish
// on the accepting edge instead of running the full iteration loop.
module muldiv_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_op1,
    input  logic [WIDTH-1:0] i_op2,
    input  logic             i_flush,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_result
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned PW    = 2 * WIDTH;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_REM    = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [2:0]         op_q;
    logic [WIDTH-1:0]   acc_hi;     // product high half / partial remainder
    logic [WIDTH-1:0]   acc_lo;     // multiplier & product low half / dividend & quotient
    logic [WIDTH-1:0]   opb_q;      // multiplicand magnitude / divisor magnitude
    logic               neg_q;      // negate product or quotient
    logic               neg_r_q;    // negate remainder (follows dividend)
    logic               dz_q;       // divide by zero: quotient forced to all ones

    logic               accept;
    logic               s1_in;
    logic               s2_in;
    logic               neg1_in;
    logic               neg2_in;
    logic [WIDTH-1:0]   mag1_in;
    logic [WIDTH-1:0]   mag2_in;
    logic               dz_in;
    logic               early_in;
    logic [WIDTH-1:0]   early_res;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     r_sh;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   acc_hi_nxt;
    logic [WIDTH-1:0]   acc_lo_nxt;

    logic [PW-1:0]      prod;
    logic [PW-1:0]      prod_s;
    logic [WIDTH-1:0]   quo_s;
    logic [WIDTH-1:0]   rem_s;
    logic [WIDTH-1:0]   fix_res;

    logic               ready_nxt;
    logic               valid_nxt;
    logic [WIDTH-1:0]   result_nxt;

    // Request decode: operand signedness, magnitudes and corner-case detection
    always_comb begin
        accept  = i_valid && (state == ST_IDLE) && !i_flush;
        s1_in   = (i_op == OP_MULH) || (i_op == OP_MULHSU) ||
                  (i_op == OP_DIV)  || (i_op == OP_REM);
        s2_in   = (i_op == OP_MULH) || (i_op == OP_DIV) || (i_op == OP_REM);
        neg1_in = s1_in && i_op1[WIDTH-1];
        neg2_in = s2_in && i_op2[WIDTH-1];
        mag1_in = neg1_in ? (~i_op1 + WIDTH'(1)) : i_op1;
        mag2_in = neg2_in ? (~i_op2 + WIDTH'(1)) : i_op2;
        dz_in   = i_op[2] && (i_op2 == '0);
`ifdef MULDIV_EARLY_OUT_EN
        early_in = dz_in ||
                   (i_op[2] && !i_op[0] &&
                    (i_op1 == {1'b1, {(WIDTH-1){1'b0}}}) && (i_op2 == '1));
        // REM/REMU take op1 on divide-by-zero and 0 on overflow; DIV/DIVU take all-ones or op1
        if (i_op[1]) begin
            early_res = dz_in ? i_op1 : '0;
        end else begin
            early_res = dz_in ? '1 : i_op1;
        end
`else
        early_in  = 1'b0;
        early_res = '0;
`endif
    end

    // One multiply or divide iteration on the shared accumulator pair
    always_comb begin
        mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb_q} : '0);
        r_sh    = {acc_hi, acc_lo[WIDTH-1]};
        diff    = r_sh - {1'b0, opb_q};
        if (op_q[2]) begin
            if (!diff[WIDTH]) begin
                acc_hi_nxt = diff[WIDTH-1:0];
                acc_lo_nxt = {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                acc_hi_nxt = r_sh[WIDTH-1:0];
                acc_lo_nxt = {acc_lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_hi_nxt = mul_sum[WIDTH:1];
            acc_lo_nxt = {mul_sum[0], acc_lo[WIDTH-1:1]};
        end
    end

    // Sign fix-up and result selection
    always_comb begin
        prod   = {acc_hi, acc_lo};
        prod_s = neg_q   ? (~prod + PW'(1))      : prod;
        quo_s  = neg_q   ? (~acc_lo + WIDTH'(1)) : acc_lo;
        rem_s  = neg_r_q ? (~acc_hi + WIDTH'(1)) : acc_hi;
        case (op_q)
            3'b000:                 fix_res = prod_s[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: fix_res = prod_s[PW-1:WIDTH];
            3'b100, 3'b101:         fix_res = dz_q ? '1 : quo_s;
            default:                fix_res = rem_s;
        endcase
    end

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; flush returns to IDLE from anywhere
    always_comb begin
        state_nxt = state;
        if (i_flush) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (accept) state_nxt = early_in ? ST_DONE : ST_CALC;
                ST_CALC: if (cnt == CNT_W'(WIDTH - 1)) state_nxt = ST_FIX;
                ST_FIX:  state_nxt = ST_DONE;
                ST_DONE: state_nxt = ST_IDLE;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // Next values of the registered outputs
    always_comb begin
        ready_nxt  = (state_nxt == ST_IDLE);
        valid_nxt  = (state_nxt == ST_DONE);
        result_nxt = o_result;
        if (!i_flush) begin
            if (state == ST_FIX) begin
                result_nxt = fix_res;
            end else if (accept && early_in) begin
                result_nxt = early_res;
            end
        end
    end

    // Registered outputs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_ready  <= 1'b1;
            o_valid  <= 1'b0;
            o_result <= '0;
        end else begin
            o_ready  <= ready_nxt;
            o_valid  <= valid_nxt;
            o_result <= result_nxt;
        end
    end

    // Operand latch on accept, iteration in CALC
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt     <= '0;
            op_q    <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            opb_q   <= '0;
            neg_q   <= 1'b0;
            neg_r_q <= 1'b0;
            dz_q    <= 1'b0;
        end else if (accept) begin
            cnt     <= '0;
            op_q    <= i_op;
            acc_hi  <= '0;
            acc_lo  <= i_op[2] ? mag1_in : mag2_in;
            opb_q   <= i_op[2] ? mag2_in : mag1_in;
            neg_q   <= neg1_in ^ neg2_in;
            neg_r_q <= neg1_in;
            dz_q    <= dz_in;
        end else if (state == ST_CALC) begin
            cnt     <= cnt + CNT_W'(1);
            acc_hi  <= acc_hi_nxt;
            acc_lo  <= acc_lo_nxt;
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed testbench for muldiv_seq (WIDTH=32).
module tb_muldiv_seq;

    logic        clk;
    logic        rst;
    logic        i_valid;
    logic        o_ready;
    logic [2:0]  i_op;
    logic [31:0] i_op1;
    logic [31:0] i_op2;
    logic        i_flush;
    logic        o_valid;
    logic [31:0] o_result;

    int n_checks = 0;
    int n_pass   = 0;

`ifdef MULDIV_EARLY_OUT_EN
    localparam int EARLY_LAT = 1;
`else
    localparam int EARLY_LAT = 34;
`endif

    muldiv_seq #(.WIDTH(32)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_op     (i_op),
        .i_op1    (i_op1),
        .i_op2    (i_op2),
        .i_flush  (i_flush),
        .o_valid  (o_valid),
        .o_result (o_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one op, scramble inputs after accept, check result, latency and busy ready
    task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int n;
        logic busy_ok;
        @(negedge clk);
        i_valid = 1'b1; i_op = op; i_op1 = a; i_op2 = b;
        @(posedge clk); #1;
        i_valid = 1'b0; i_op = 3'($urandom); i_op1 = $urandom; i_op2 = $urandom;
        n = 1;
        busy_ok = 1'b1;
        while (!o_valid && n < 100) begin
            if (o_ready) busy_ok = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        if (o_ready) busy_ok = 1'b0;
        check({tag, "_valid"}, 32'(o_valid), 32'd1);
        check({tag, "_res"}, o_result, exp);
        check({tag, "_lat"}, 32'(n), 32'(exp_lat));
        check({tag, "_busy"}, 32'(busy_ok), 32'd1);
        @(posedge clk); #1;
        check({tag, "_pulse"}, {30'd0, o_valid, o_ready}, 32'd1);
    endtask

    // Watch for a bounded window and report whether any o_valid appeared
    task automatic watch_quiet(input string tag, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (o_valid) seen++;
        end
        check(tag, 32'(seen), 32'd0);
    endtask

    initial begin
        int first_v;
        int second_v;
        int n_v;
        logic [31:0] prev_res;

        rst = 1'b1; i_valid = 1'b0; i_op = '0; i_op1 = '0; i_op2 = '0; i_flush = 1'b0;
        #12;
        check("rst_ready", 32'(o_ready), 32'd1);
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_result", o_result, 32'd0);
        @(negedge clk); rst = 1'b0;

        // Multiply
        do_op("mul_7x6",       3'b000, 32'd7,        32'd6,        32'h0000_002A, 34);
        do_op("mul_neg3x5",    3'b000, 32'hFFFF_FFFD, 32'd5,       32'hFFFF_FFF1, 34);
        do_op("mulh_m1m1",     3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 34);
        do_op("mulhu_m1m1",    3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
        do_op("mulhsu_m1x2",   3'b010, 32'hFFFF_FFFF, 32'd2,       32'hFFFF_FFFF, 34);
        do_op("mulh_min_min",  3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);

        // Divide
        do_op("div_m7_2",      3'b100, 32'hFFFF_FFF9, 32'd2,       32'hFFFF_FFFD, 34);
        do_op("rem_m7_2",      3'b110, 32'hFFFF_FFF9, 32'd2,       32'hFFFF_FFFF, 34);
        do_op("divu_100_7",    3'b101, 32'd100,      32'd7,        32'd14,        34);
        do_op("remu_100_7",    3'b111, 32'd100,      32'd7,        32'd2,         34);
        do_op("div_7_m2",      3'b100, 32'd7,        32'hFFFF_FFFE, 32'hFFFF_FFFD, 34);
        do_op("rem_7_m2",      3'b110, 32'd7,        32'hFFFF_FFFE, 32'd1,         34);

        // Divide corner cases
        do_op("div_5_0",       3'b100, 32'd5,        32'd0,        32'hFFFF_FFFF, EARLY_LAT);
        do_op("rem_5_0",       3'b110, 32'd5,        32'd0,        32'd5,         EARLY_LAT);
        do_op("divu_5_0",      3'b101, 32'd5,        32'd0,        32'hFFFF_FFFF, EARLY_LAT);
        do_op("remu_5_0",      3'b111, 32'd5,        32'd0,        32'd5,         EARLY_LAT);
        do_op("rem_m5_0",      3'b110, 32'hFFFF_FFFB, 32'd0,       32'hFFFF_FFFB, EARLY_LAT);
        do_op("div_ovf",       3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, EARLY_LAT);
        do_op("rem_ovf",       3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,       EARLY_LAT);
        do_op("divu_min_m1",   3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,       34);

        // Flush 10 cycles into a DIVU
        prev_res = o_result;
        @(negedge clk);
        i_valid = 1'b1; i_op = 3'b101; i_op1 = 32'd1000; i_op2 = 32'd3;
        @(posedge clk); #1;
        i_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk); i_flush = 1'b1;
        @(posedge clk); #1;
        check("flush_ready", 32'(o_ready), 32'd1);
        check("flush_valid", 32'(o_valid), 32'd0);
        check("flush_result", o_result, prev_res);
        @(negedge clk); i_flush = 1'b0;
        watch_quiet("flush_no_valid", 40);

        // Flush together with i_valid in IDLE does not accept
        @(negedge clk);
        i_flush = 1'b1; i_valid = 1'b1; i_op = 3'b000; i_op1 = 32'd4; i_op2 = 32'd4;
        @(posedge clk); #1;
        check("flush_idle_ready", 32'(o_ready), 32'd1);
        @(negedge clk); i_flush = 1'b0; i_valid = 1'b0;
        watch_quiet("flush_idle_quiet", 40);
        do_op("mul_3x3", 3'b000, 32'd3, 32'd3, 32'd9, 34);

        // Async reset mid-MUL
        @(negedge clk);
        i_valid = 1'b1; i_op = 3'b000; i_op1 = 32'd11; i_op2 = 32'd13;
        @(posedge clk); #1;
        i_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_ready", 32'(o_ready), 32'd1);
        check("arst_valid", 32'(o_valid), 32'd0);
        check("arst_result", o_result, 32'd0);
        @(negedge clk); rst = 1'b0;
        watch_quiet("arst_quiet", 40);

        // Hold i_valid high: accepts only in IDLE, spaced by DONE->IDLE
        @(negedge clk);
        i_valid = 1'b1; i_op = 3'b000; i_op1 = 32'd2; i_op2 = 32'd3;
        first_v = 0; second_v = 0; n_v = 0;
        for (int n = 1; n <= 70; n++) begin
            @(posedge clk); #1;
            if (o_valid) begin
                n_v++;
                if (n_v == 1) first_v = n;
                if (n_v == 2) second_v = n;
                check("hold_res", o_result, 32'd6);
            end
        end
        @(negedge clk); i_valid = 1'b0;
        check("hold_count", 32'(n_v), 32'd2);
        check("hold_first", 32'(first_v), 32'd34);
        check("hold_second", 32'(second_v), 32'd69);
        @(posedge clk); #1;
        check("hold_idle", 32'(o_ready), 32'd1);
        watch_quiet("hold_quiet", 40);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
